// File: rtl/perceptron_n.sv
// perceptron_n -- time-multiplexed single perceptron.
//
// A vector arrives as a stream of (in_data, in_weight) beats. The first beat
// also carries the bias and the activation select. Products are summed at
// full precision, the sum is shifted back to Q(DWIDTH-FRAC).FRAC with floor
// rounding and saturated, then optionally passed through the sigmoid. The
// registered result is held on a valid/ready output until it is taken.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   act_en     1 = sigmoid, 0 = identity (sampled with first beat)
//   bias       bias value (sampled with first beat)
//   in_valid   beat valid
//   in_ready   block can accept a beat (registered)
//   in_data    input value
//   in_weight  weight for in_data
//   in_last    final beat of the vector
//   out_valid  result valid (registered)
//   out_ready  downstream accepts the result
//   out_data   activated result (registered)
//   out_trunc  vector was closed by the NIN-beat limit, not by in_last
module perceptron_n #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24,
  parameter int NIN    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act_en,
  input  logic [DWIDTH-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [DWIDTH-1:0] in_weight,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_trunc
);

  localparam int CW = $clog2(NIN + 1);
  localparam int PW = 2 * DWIDTH;
  localparam int AW = PW + CW;

  localparam logic [CW-1:0] LAST_CNT = CW'(NIN - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [DWIDTH-1:0] SAT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SAT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

  // Sigmoid constants: 0.5 and 1.0 in the data format, one guard bit wide.
  localparam logic signed [DWIDTH:0] SIG_HALF = (DWIDTH+1)'(64'd1 << (FRAC - 1));
  localparam logic signed [DWIDTH:0] SIG_ONE  = (DWIDTH+1)'(64'd1 << FRAC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_n;

  logic [AW-1:0]     acc_r;
  logic [CW-1:0]     cnt_r;
  logic              act_r;
  logic              trunc_r;
  logic              in_ready_r;

  logic              fire_s;
  logic              close_s;
  logic [PW-1:0]     prod_s;
  logic [AW-1:0]     prod_ext_s;
  logic [AW-1:0]     bias_ext_s;
  logic [AW-1:0]     sum_s;
  logic              fits_s;
  logic [DWIDTH-1:0] sat_s;
  logic [DWIDTH-1:0] act_s;

  // Shared sigmoid unit: hard sigmoid clamp(x/4 + 0.5, 0, 1). The divide by
  // four is an arithmetic shift (floor); the guard bit keeps x/4 + 0.5 from
  // overflowing before the clamp.
  function automatic logic [DWIDTH-1:0] sigmf(input logic [DWIDTH-1:0] x);
    logic signed [DWIDTH:0] xe;
    logic signed [DWIDTH:0] y;
    logic [DWIDTH-1:0]      r;
    xe = $signed({x[DWIDTH-1], x});
    y  = (xe >>> 2) + SIG_HALF;
    if (y[DWIDTH]) begin
      r = {DWIDTH{1'b0}};
    end else if (y > SIG_ONE) begin
      r = SIG_ONE[DWIDTH-1:0];
    end else begin
      r = y[DWIDTH-1:0];
    end
    return r;
  endfunction

  assign in_ready = in_ready_r;
  assign fire_s   = in_valid && in_ready_r;

  // Beat datapath: full-width product, sign-extended bias aligned to the product scale.
  always_comb begin
    prod_s     = {PW{1'b0}};
    prod_ext_s = {AW{1'b0}};
    bias_ext_s = {AW{1'b0}};
    prod_s     = $signed({{DWIDTH{in_data[DWIDTH-1]}}, in_data}) *
                 $signed({{DWIDTH{in_weight[DWIDTH-1]}}, in_weight});
    prod_ext_s = {{CW{prod_s[PW-1]}}, prod_s};
    bias_ext_s = {{(AW-DWIDTH){bias[DWIDTH-1]}}, bias} << FRAC;
  end

  // A beat closes the vector on in_last or when it is the NIN-th beat (NIN >= 2,
  // so the first beat can only close on in_last).
  always_comb begin
    close_s = 1'b0;
    if (in_last) begin
      close_s = 1'b1;
    end else if ((state_r == ACC) && (cnt_r == LAST_CNT)) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Result path: floor shift, saturate when the upper bits are not all sign, activate.
  always_comb begin
    sum_s  = {AW{1'b0}};
    fits_s = 1'b0;
    sat_s  = {DWIDTH{1'b0}};
    act_s  = {DWIDTH{1'b0}};
    sum_s  = $signed(acc_r) >>> FRAC;
    fits_s = (&sum_s[AW-1:DWIDTH-1]) || (~|sum_s[AW-1:DWIDTH-1]);
    if (fits_s) begin
      sat_s = sum_s[DWIDTH-1:0];
    end else if (sum_s[AW-1]) begin
      sat_s = SAT_MIN;
    end else begin
      sat_s = SAT_MAX;
    end
    if (act_r) begin
      act_s = sigmf(sat_s);
    end else begin
      act_s = sat_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, ACC: begin
        if (fire_s) begin
          state_n = close_s ? ACT : ACC;
        end else begin
          state_n = state_r;
        end
      end
      ACT: begin
        state_n = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = OUT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Accumulator, beat counter, latched controls and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r      <= {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      act_r      <= 1'b0;
      trunc_r    <= 1'b0;
      in_ready_r <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= {DWIDTH{1'b0}};
      out_trunc  <= 1'b0;
    end else begin
      // in_ready is decoded from the next state so it is a clean flop output.
      in_ready_r <= (state_n == IDLE) || (state_n == ACC);
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            acc_r   <= bias_ext_s + prod_ext_s;
            cnt_r   <= ONE_CNT;
            act_r   <= act_en;
            trunc_r <= close_s && !in_last;
          end
        end
        ACC: begin
          if (fire_s) begin
            acc_r   <= acc_r + prod_ext_s;
            cnt_r   <= cnt_r + ONE_CNT;
            trunc_r <= close_s && !in_last;
          end
        end
        ACT: begin
          out_data  <= act_s;
          out_trunc <= trunc_r;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_n.sv
// tb_perceptron_n -- self-checking bench for perceptron_n (NIN = 4).
// Directed cases from the design's behaviour list followed by random vectors
// checked against an arithmetic reference (exact sum, floor divide, clamp,
// hard sigmoid clamp(x/4 + 0.5, 0, 1)).
module tb_perceptron_n;

  localparam int DW = 32;
  localparam int FR = 24;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          act_en;
  logic [DW-1:0] bias;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_weight;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_trunc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perceptron_n #(.DWIDTH(DW), .FRAC(FR), .NIN(NI)) dut (
    .clk(clk), .rst(rst), .act_en(act_en), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_trunc(out_trunc)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Floor division of a signed value by a positive divisor.
  function automatic logic signed [127:0] fdiv(input logic signed [127:0] a,
                                               input logic signed [127:0] d);
    logic signed [127:0] q;
    q = a / d;
    if (a < 0 && q * d != a) q = q - 128'sd1;
    return q;
  endfunction

  // Reference: exact total (raw product scale) -> floor to data scale -> clamp -> activation.
  function automatic logic [31:0] ref_out(input logic signed [127:0] tot, input logic act);
    logic signed [127:0] q;
    logic signed [127:0] h;
    q = fdiv(tot, 128'sd16777216);
    if (q > 128'sd2147483647) q = 128'sd2147483647;
    else if (q < -128'sd2147483648) q = -128'sd2147483648;
    if (act) begin
      h = fdiv(q, 128'sd4) + 128'sd8388608;
      if (h < 128'sd0) h = 128'sd0;
      else if (h > 128'sd16777216) h = 128'sd16777216;
      q = h;
    end
    return q[31:0];
  endfunction

  // Present one beat, wait (bounded) for in_ready, return #1 after the accepting edge.
  task automatic beat(input logic [31:0] d, input logic [31:0] w, input logic last,
                      input logic act, input logic [31:0] b);
    int n = 0;
    in_data = d; in_weight = w; in_last = last; act_en = act; bias = b; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk({31'd0, in_ready}, 32'd1, "beat_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for a result, optionally stall it, check it, then take it.
  task automatic take(input logic [31:0] exp_d, input logic exp_t, input int stall,
                      input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({31'd0, out_valid}, 32'd1, {tag, "_valid"});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk(out_data, exp_d, {tag, "_hold"});
      chk({31'd0, in_ready}, 32'd0, {tag, "_hold_rdy"});
    end
    chk(out_data, exp_d, {tag, "_data"});
    chk({31'd0, out_trunc}, {31'd0, exp_t}, {tag, "_trunc"});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({31'd0, out_valid}, 32'd0, {tag, "_taken"});
    chk({31'd0, in_ready}, 32'd1, {tag, "_rdy_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [127:0] mtot;
    logic [31:0] d, w, b, r;
    int len, stall;
    logic use_last, act, trunc_exp;
    int n;

    rst = 1'b1; act_en = 1'b0; bias = 32'd0; in_valid = 1'b0; in_data = 32'd0;
    in_weight = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    // Reset state.
    chk({31'd0, out_valid}, 32'd0, "rst_valid");
    chk(out_data, 32'd0, "rst_data");
    chk({31'd0, out_trunc}, 32'd0, "rst_trunc");
    chk({31'd0, in_ready}, 32'd1, "rst_ready");

    // Three-beat vector with bias 0.25 -> 0.75, and latency.
    beat(32'h01000000, 32'h00800000, 1'b0, 1'b0, 32'h00400000);
    beat(32'h02000000, 32'h00400000, 1'b0, 1'b0, 32'h00400000);
    beat(32'hFF000000, 32'h00800000, 1'b1, 1'b0, 32'h00400000);
    chk({31'd0, out_valid}, 32'd0, "lat_act_cycle");
    chk({31'd0, in_ready}, 32'd0, "lat_act_rdy");
    @(posedge clk); #1;
    chk({31'd0, out_valid}, 32'd1, "lat_out_cycle");
    take(32'h00C00000, 1'b0, 0, "vec3");

    // Saturation both ways.
    beat(32'h64000000, 32'h64000000, 1'b1, 1'b0, 32'd0);
    take(32'h7FFFFFFF, 1'b0, 0, "sat_pos");
    beat(32'h9C000000, 32'h64000000, 1'b1, 1'b0, 32'd0);
    take(32'h80000000, 1'b0, 0, "sat_neg");

    // Floor rounding.
    beat(32'h00000001, 32'h00800000, 1'b1, 1'b0, 32'd0);
    take(32'h00000000, 1'b0, 0, "floor_pos");
    beat(32'hFFFFFFFF, 32'h00800000, 1'b1, 1'b0, 32'd0);
    take(32'hFFFFFFFF, 1'b0, 0, "floor_neg");

    // NIN-beat truncation; a waiting fifth beat starts a new vector after the output is taken.
    for (int i = 0; i < NI; i++) beat(32'h01000000, 32'h01000000, 1'b0, 1'b0, 32'd0);
    chk({31'd0, in_ready}, 32'd0, "trunc_closed");
    in_data = 32'h02000000; in_weight = 32'h01000000; in_last = 1'b1;
    act_en = 1'b0; bias = 32'd0; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({31'd0, out_valid}, 32'd1, "trunc_valid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk({31'd0, in_ready}, 32'd0, "trunc_stall_rdy");
      chk(out_data, 32'h04000000, "trunc_stall_data");
    end
    chk({31'd0, out_trunc}, 32'd1, "trunc_flag");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({31'd0, in_ready}, 32'd1, "fifth_ready");
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    take(32'h02000000, 1'b0, 0, "fifth");

    // Sigmoid of zero, with 5-cycle backpressure and a beat offered during the stall.
    beat(32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_data = 32'h7F000000; in_weight = 32'h7F000000; in_last = 1'b1;
    act_en = 1'b0; in_valid = 1'b1;
    take(32'h00800000, 1'b0, 5, "bp");
    in_valid = 1'b0; in_last = 1'b0;
    beat(32'h01000000, 32'h01000000, 1'b1, 1'b0, 32'd0);
    take(32'h01000000, 1'b0, 0, "bp_next");

    // Reset mid-vector discards the partial sum.
    beat(32'h10000000, 32'h10000000, 1'b0, 1'b0, 32'h00400000);
    beat(32'h10000000, 32'h10000000, 1'b0, 1'b0, 32'h00400000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({31'd0, out_valid}, 32'd0, "rst_mid_valid");
    chk({31'd0, in_ready}, 32'd1, "rst_mid_ready");
    beat(32'h01000000, 32'h01000000, 1'b1, 1'b0, 32'd0);
    take(32'h01000000, 1'b0, 0, "rst_vec");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk({31'd0, out_valid}, 32'd0, "rst_no_extra");
    end

    // Random vectors against the reference.
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, NI);
      use_last = (len < NI) ? 1'b1 : 1'($urandom_range(0, 1));
      act = 1'($urandom_range(0, 1));
      r = $urandom;
      b = {{6{r[25]}}, r[25:0]};
      mtot = $signed(b) * 128'sd16777216;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          d = $urandom; w = $urandom;
        end else begin
          r = $urandom; d = {{6{r[25]}}, r[25:0]};
          r = $urandom; w = {{8{r[23]}}, r[23:0]};
        end
        mtot = mtot + $signed(d) * $signed(w);
        beat(d, w, (i == len - 1) ? use_last : 1'b0, act, b);
      end
      trunc_exp = (len == NI) && !use_last;
      stall = $urandom_range(0, 3);
      take(ref_out(mtot, act), trunc_exp, stall, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
